pwm_dac_capture: RTL and testbench
==================================

Name: pwm_dac_capture

Overview:
- Receiving end of the Slipstream two-channel PWM DAC interface.
- Watches the coarse (PW_2) and fine (PW_1) pulse-width streams, clocked by the XCK tick, and measures each channel's high time per PWM period.
- Rebuilds the 14-bit DAC word {coarse, fine} as a sample stream.
- Used by the MiSTer audio path and as a self-check monitor on the PWM outputs.

Parameters:
- CNT_BITS, 7: width of each channel's period and high-time counter. The period is 2^CNT_BITS XCK ticks.
- SYNC_STAGES, 2: flops in the synchroniser on PW_1 and PW_2. Legal values are 2..3.

Ports:
- MasterClock, input, 1: system clock. All logic is on its rising edge.
- RESETL, input, 1: asynchronous active-low reset.
- XCK, input, 1: PWM tick enable, a one-MasterClock pulse synchronous to MasterClock.
- PW_1, input, 1: fine-channel PWM stream (DAC bits 6:0).
- PW_2, input, 1: coarse-channel PWM stream (DAC bits 13:7, MSB already inverted).
- DAC, output, 2*CNT_BITS: last reconstructed sample, {hi2, hi1}.
- SAMPLE_VALID, output, 1: one-cycle pulse when DAC updates.
- LOCKED, output, 1: period alignment established.
- RESYNC_ERR, output, 1: one-cycle pulse when a period-misaligned pulse edge is seen.

Behaviour:
- Reset: asynchronous on RESETL low.
  - DAC=0, SAMPLE_VALID=0, LOCKED=0, RESYNC_ERR=0.
  - Synchronisers = 0, all counters = 0, state = HUNT.
- Input path:
  - PW_1 and PW_2 each pass through SYNC_STAGES flops.
  - A registered previous value gives rising-edge detect r1 and r2, evaluated only on XCK ticks.
- Pulse convention: a PWM pulse starts at phase 0 and is high for N ticks, N in 0..2^CNT_BITS-1.
- State machine (advances only on cycles with XCK=1):
  - HUNT:
    - phase, hi1 and hi2 are held at 0.
    - On r1 or r2: go to LOCKED, set phase=1, hi1 = PW_1 sync value, hi2 = PW_2 sync value. This tick counts as phase 0.
  - LOCKED, per tick:
    - phase++ (wraps).
    - hi1 += PW_1 sync value; hi2 += PW_2 sync value.
  - LOCKED, on the tick where phase == 2^CNT_BITS-1:
    - Latch {hi2_next, hi1_next} into DAC and pulse SAMPLE_VALID on the following cycle.
    - Clear hi1, hi2 and phase to 0.
  - LOCKED, on r1 or r2 at phase != 0:
    - Pulse RESYNC_ERR.
    - Discard the partial counts. Restart at phase=1 with counts seeded from this tick, as in the HUNT entry.
    - No sample is emitted for the broken period. LOCKED stays 1.
- Latency: DAC updates exactly one MasterClock after the last tick of the period.
- Counter widths: hi counters are CNT_BITS wide. A value of 2^CNT_BITS-1 is the maximum and cannot overflow, because a pulse is never high at phase 0 of the next period before the clear.
- Boundary cases:
  - Zero duty on both channels produces no edges. LOCKED holds and DAC=0 is emitted each period.
  - Simultaneous r1 and r2 count as one event.
  - XCK held low: all state is frozen and SAMPLE_VALID stays 0.
  - RESETL asserted mid-period: immediate return to HUNT. The partial sample is lost and DAC is cleared.

Optional Feature:
- Macro: PWM_DAC_CAPTURE_PCM_EN.
- Defined:
  - Adds an output PCM [15:0] = {~DAC[13], DAC[12:0], 2'b00}, a signed two's-complement audio sample.
  - PCM updates with DAC and resets to 16'h8000.
- Undefined: no PCM port and no extra logic.

Decomposition:
- Shared package slipstream_pwm_pkg holds:
  - PWM_CNT_BITS = 7.
  - typedef pwm_cnt_t (logic [PWM_CNT_BITS-1:0]).
  - typedef enum {PWR_HUNT, PWR_LOCKED} pwm_rx_state_t.
- One natural sub-module, pwm_width_meter: per-channel synchroniser, edge detect and high-time counter. Instantiate it twice; the top holds the shared phase counter and FSM.

Test Plan:
1. Reset then drive a PWM model with word 14'h2A55 (hi2=0x54, hi1=0x55), XCK every 4 clocks. Expect LOCKED=1 after the first edge, the first SAMPLE_VALID after 128 ticks, and DAC=14'h2A55 every period thereafter.
2. Word 14'h0000. Never locks, because there are no edges: LOCKED=0 and SAMPLE_VALID never pulses. Then switch to 14'h0081. Expect lock, then DAC=14'h0081.
3. Word 14'h3FFF (both channels 127 high). Expect DAC=14'h3FFF with no overflow and no RESYNC_ERR.
4. While locked, inject a PW_1 rising edge at phase 40. Expect a RESYNC_ERR pulse, no SAMPLE_VALID at the old boundary, and a correct sample 128 ticks after the injected edge.
5. Assert RESETL low at phase 60. Expect immediate DAC=0, LOCKED=0, HUNT, then relock on the next period.
6. With PWM_DAC_CAPTURE_PCM_EN defined and DAC=14'h2000, expect PCM=16'h0000. With DAC=14'h0000, expect PCM=16'h8000.

Source files
------------

// File: rtl/slipstream_pwm_pkg.sv
// slipstream_pwm_pkg: shared counter width, counter type and receiver states for the Slipstream PWM DAC link
package slipstream_pwm_pkg;
  localparam int PWM_CNT_BITS = 7;
  typedef logic [PWM_CNT_BITS-1:0] pwm_cnt_t;
  typedef enum logic {PWR_HUNT, PWR_LOCKED} pwm_rx_state_t;
endpackage

// File: rtl/pwm_dac_capture_if.sv
// pwm_dac_capture_if: PWM stream inputs and reconstructed sample outputs of the capture block
//   XCK, PW_1, PW_2 : tick enable, fine and coarse PWM streams (source -> capture)
//   DAC, SAMPLE_VALID, LOCKED, RESYNC_ERR : reconstructed word and status (capture -> sink)
//   PCM : signed 16-bit sample, present only with PWM_DAC_CAPTURE_PCM_EN
interface pwm_dac_capture_if import slipstream_pwm_pkg::*; #(parameter int CNT_BITS = PWM_CNT_BITS);
  logic XCK;
  logic PW_1;
  logic PW_2;
  logic [2*CNT_BITS-1:0] DAC;
  logic SAMPLE_VALID;
  logic LOCKED;
  logic RESYNC_ERR;
`ifdef PWM_DAC_CAPTURE_PCM_EN
  logic [15:0] PCM;
  modport master(output XCK, PW_1, PW_2, input DAC, SAMPLE_VALID, LOCKED, RESYNC_ERR, PCM);
  modport slave(input XCK, PW_1, PW_2, output DAC, SAMPLE_VALID, LOCKED, RESYNC_ERR, PCM);
`else
  modport master(output XCK, PW_1, PW_2, input DAC, SAMPLE_VALID, LOCKED, RESYNC_ERR);
  modport slave(input XCK, PW_1, PW_2, output DAC, SAMPLE_VALID, LOCKED, RESYNC_ERR);
`endif
endinterface

// File: rtl/pwm_width_meter.sv
// pwm_width_meter: one channel's synchroniser, tick-gated rising-edge detect and high-time counter
//   clk, rst_n : clock, async active-low reset
//   tick       : XCK enable
//   pw         : raw PWM stream
//   seed, clr  : on a tick, restart the count from this tick's value / from zero
//   rise       : rising edge seen on this tick
//   hi_next    : count including this tick's sample
module pwm_width_meter import slipstream_pwm_pkg::*; #(
  parameter int CNT_BITS = PWM_CNT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pw,
  input  logic seed,
  input  logic clr,
  output logic rise,
  output logic [CNT_BITS-1:0] hi_next
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic [CNT_BITS-1:0] hi;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign rise = tick & s & ~prev;
  assign hi_next = hi + CNT_BITS'(s);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      hi <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pw};
      if (tick) begin
        prev <= s;
        hi <= seed ? CNT_BITS'(s) : clr ? '0 : hi_next;
      end
    end
  end
endmodule

// File: rtl/pwm_dac_capture.sv
// pwm_dac_capture: rebuilds the 14-bit Slipstream DAC word from the coarse/fine PWM streams
//   MasterClock : system clock
//   RESETL      : async active-low reset
//   bus         : slave side of pwm_dac_capture_if (PWM inputs, DAC/status outputs)
//   PWM_DAC_CAPTURE_PCM_EN adds bus.PCM = {~DAC[MSB], DAC[MSB-1:0], zero pad}
module pwm_dac_capture import slipstream_pwm_pkg::*; #(
  parameter int CNT_BITS = PWM_CNT_BITS,
  parameter int SYNC_STAGES = 2
) (
  input logic MasterClock,
  input logic RESETL,
  pwm_dac_capture_if.slave bus
);
  pwm_rx_state_t state, state_n;
  logic [CNT_BITS-1:0] phase, phase_n, hi1_next, hi2_next;
  logic [2*CNT_BITS-1:0] dac;
  logic r1, r2, ev, seed, clr, latch, rerr, sample_valid, resync_err;
  pwm_width_meter #(.CNT_BITS(CNT_BITS), .SYNC_STAGES(SYNC_STAGES)) u_fine (
    .clk(MasterClock), .rst_n(RESETL), .tick(bus.XCK), .pw(bus.PW_1),
    .seed(seed), .clr(clr), .rise(r1), .hi_next(hi1_next)
  );
  pwm_width_meter #(.CNT_BITS(CNT_BITS), .SYNC_STAGES(SYNC_STAGES)) u_coarse (
    .clk(MasterClock), .rst_n(RESETL), .tick(bus.XCK), .pw(bus.PW_2),
    .seed(seed), .clr(clr), .rise(r2), .hi_next(hi2_next)
  );
  assign ev = r1 | r2;
  // An edge at phase 0 is the expected period start; anywhere else it re-anchors the period.
  always_comb begin
    state_n = state;
    phase_n = phase;
    seed = 1'b0;
    clr = 1'b0;
    latch = 1'b0;
    rerr = 1'b0;
    if (bus.XCK) begin
      if (state == PWR_HUNT) begin
        seed = ev;
        clr = !ev;
        state_n = ev ? PWR_LOCKED : PWR_HUNT;
        phase_n = ev ? CNT_BITS'(1) : '0;
      end else if (ev && phase != '0) begin
        rerr = 1'b1;
        seed = 1'b1;
        phase_n = CNT_BITS'(1);
      end else begin
        latch = &phase;
        clr = &phase;
        phase_n = phase + CNT_BITS'(1);
      end
    end
  end
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state <= PWR_HUNT;
      phase <= '0;
      dac <= '0;
      sample_valid <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      dac <= latch ? {hi2_next, hi1_next} : dac;
      sample_valid <= latch;
      resync_err <= rerr;
    end
  end
  assign bus.DAC = dac;
  assign bus.SAMPLE_VALID = sample_valid;
  assign bus.LOCKED = state == PWR_LOCKED;
  assign bus.RESYNC_ERR = resync_err;
`ifdef PWM_DAC_CAPTURE_PCM_EN
  assign bus.PCM = {~dac[2*CNT_BITS-1], dac[2*CNT_BITS-2:0], {(16-2*CNT_BITS){1'b0}}};
`endif
endmodule

// File: tb/tb_pwm_dac_capture.sv
// tb_pwm_dac_capture: randomized PWM source against a windowed high-time reference model
module tb_pwm_dac_capture;
  import slipstream_pwm_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pwm_dac_capture_if bus();
  pwm_dac_capture dut(.MasterClock(clk), .RESETL(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic m_locked, m_prev1, m_prev2, m_sv, m_re;
  logic [13:0] m_dac;
  logic [1:0] win[$];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_locked = 1'b0;
    m_prev1 = 1'b0;
    m_prev2 = 1'b0;
    m_sv = 1'b0;
    m_re = 1'b0;
    m_dac = '0;
    win.delete();
  endtask
  // Sample = number of high ticks of each channel in a 128-tick window anchored on an edge.
  task automatic model_step(input logic b1, input logic b2);
    logic r;
    int s1, s2;
    r = (b1 && !m_prev1) || (b2 && !m_prev2);
    m_prev1 = b1;
    m_prev2 = b2;
    m_sv = 1'b0;
    m_re = 1'b0;
    if (r && m_locked && win.size() != 0) begin
      m_re = 1'b1;
      win.delete();
    end
    if (r) m_locked = 1'b1;
    if (m_locked) win.push_back({b2, b1});
    if (win.size() == 128) begin
      s1 = 0;
      s2 = 0;
      foreach (win[i]) begin
        s1 += int'(win[i][0]);
        s2 += int'(win[i][1]);
      end
      m_dac = {7'(s2), 7'(s1)};
      m_sv = 1'b1;
      win.delete();
    end
  endtask
  task automatic check_outputs(input string ph);
    check({ph, "_sample_valid"}, 32'(bus.SAMPLE_VALID), 32'(m_sv));
    check({ph, "_dac"}, 32'(bus.DAC), 32'(m_dac));
    check({ph, "_locked"}, 32'(bus.LOCKED), 32'(m_locked));
    check({ph, "_resync_err"}, 32'(bus.RESYNC_ERR), 32'(m_re));
`ifdef PWM_DAC_CAPTURE_PCM_EN
    check({ph, "_pcm"}, 32'(bus.PCM), 32'({~m_dac[13], m_dac[12:0], 2'b00}));
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    #1 check("idle_sample_valid", 32'(bus.SAMPLE_VALID), 32'd0);
    repeat (2) @(posedge clk);
    #1 bus.XCK = 1'b1;
    @(posedge clk);
    #1 bus.XCK = 1'b0;
    model_step(bus.PW_1, bus.PW_2);
    m_sv = m_sv;
    check_outputs("tick");
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("reset");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic hold_low(input int n);
    m_sv = 1'b0;
    m_re = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1 check_outputs("xck_low");
    end
  endtask
  // Source drives phase p before the tick that samples it; inj re-starts the source period
  // after forcing PW_1 low on phase inj-1, rsp resets the receiver at that phase.
  task automatic run_period(input logic [13:0] w, input int inj, input int rsp);
    for (int p = 0; p < 128; p++) begin
      if (p == rsp) begin
        do_reset();
        return;
      end
      bus.PW_1 = (p == inj - 1) ? 1'b0 : (p < int'(w[6:0]));
      bus.PW_2 = p < int'(w[13:7]);
      tick();
      if (p == inj - 1) return;
    end
  endtask
  initial begin
    logic [13:0] w;
    bus.XCK = 1'b0;
    bus.PW_1 = 1'b0;
    bus.PW_2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs("por");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) run_period(14'h2A55, -1, -1);
    do_reset();
    repeat (2) run_period(14'h0000, -1, -1);
    repeat (3) run_period(14'h0081, -1, -1);
    repeat (3) run_period(14'h3FFF, -1, -1);
    run_period(14'h2A55, -1, -1);
    run_period(14'h2A55, 40, -1);
    repeat (2) run_period(14'h2A55, -1, -1);
    run_period(14'h2A55, -1, 60);
    repeat (2) run_period(14'h2A55, -1, -1);
    hold_low(20);
    for (int i = 0; i < 6; i++) begin
      w = 14'($urandom);
      run_period(w, ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 127)) : -1, -1);
      run_period(w, -1, -1);
      if ($urandom_range(0, 1) == 1) hold_low(int'($urandom_range(1, 12)));
    end
`ifdef PWM_DAC_CAPTURE_PCM_EN
    do_reset();
    check("pcm_reset", 32'(bus.PCM), 32'h8000);
    repeat (2) run_period(14'h2000, -1, -1);
    check("pcm_2000", 32'(bus.PCM), 32'h0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
